bit_packer: RTL and testbench

BIT_PACKER -- requirements
Module: bit_packer

---
 rtl/bit_packer.sv | 182 ++++++++++++++++++
 tb/tb_bit_packer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_packer.sv
// bit_packer: serial-to-parallel word packer with a one-entry output holding
// register and a valid/ready handshake.
// Bits arrive on d qualified by d_valid; the first received bit lands in
// out_data[0]. A completed word moves into the holding register if it is
// empty or being drained on the same edge. Otherwise the word is dropped and
// the sticky overflow flag is raised.
// Optional feature: define BIT_PACKER_PARITY_EN to append one even-parity bit
// to every word. The parity bit is checked on arrival and reported on
// parity_err alongside out_data. Without the macro, parity_err is tied to 0.
module bit_packer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             parity_err
);

`ifdef BIT_PACKER_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [CNT_W-1:0] bitCount_q, bitCount_d;
    logic [WIDTH-1:0] collect_q,  collect_d;
    logic [WIDTH-1:0] outData_q,  outData_d;
    logic             outValid_q, outValid_d;
    logic             overflow_q, overflow_d;
`ifdef BIT_PACKER_PARITY_EN
    logic             parAcc_q,   parAcc_d;
    logic             parityErr_q, parityErr_d;
    logic             parAccBase;
    logic             completedParErr;
`endif

    logic             acceptBit;
    logic             wordDone;
    logic             canLoad;
    logic [WIDTH-1:0] collectBase;
    logic [WIDTH-1:0] collectShifted;

    // flush beats d_valid, so a bit arriving with flush is never taken.
    // A word completes when the bit that fills the last slot is accepted.
    // The holding register can take a new word if it is empty or being
    // drained on this edge.
    assign acceptBit = d_valid & ~flush;
    assign wordDone  = acceptBit & (bitCount_q == LAST_IDX);
    assign canLoad   = ~outValid_q | out_ready;

    // Insert the incoming bit at the current count position. IDLE starts
    // from a clean register so no earlier bits can leak into a new word.
    // In the parity build the last bit (count == WIDTH) matches no data
    // slot, so the data bits pass through unchanged.
    always_comb begin
        collectBase    = (state_q == IDLE) ? '0 : collect_q;
        collectShifted = collectBase;
        for (int i = 0; i < WIDTH; i++) begin
            if (bitCount_q == CNT_W'(i)) begin
                collectShifted[i] = d;
            end
        end
    end

`ifdef BIT_PACKER_PARITY_EN
    // Running XOR of every bit of the frame, parity bit included. A nonzero
    // result at completion means the even-parity check failed.
    always_comb begin
        parAccBase      = (state_q == IDLE) ? 1'b0 : parAcc_q;
        completedParErr = parAccBase ^ d;
    end
`endif

    // Serial intake: count, shift and track state. A stalled output never
    // holds this up.
    always_comb begin
        state_d    = state_q;
        bitCount_d = bitCount_q;
        collect_d  = collect_q;
`ifdef BIT_PACKER_PARITY_EN
        parAcc_d   = parAcc_q;
`endif
        if (flush) begin
            state_d    = IDLE;
            bitCount_d = '0;
            collect_d  = '0;
`ifdef BIT_PACKER_PARITY_EN
            parAcc_d   = 1'b0;
`endif
        end else if (d_valid) begin
            if (wordDone) begin
                state_d    = IDLE;
                bitCount_d = '0;
                collect_d  = '0;
`ifdef BIT_PACKER_PARITY_EN
                parAcc_d   = 1'b0;
`endif
            end else begin
                state_d    = COLLECT;
                bitCount_d = bitCount_q + 1'b1;
                collect_d  = collectShifted;
`ifdef BIT_PACKER_PARITY_EN
                parAcc_d   = completedParErr;
`endif
            end
        end
    end

    // Holding register and handshake. A completed word loads when there is
    // room; a handshake with no new word empties the register; a completed
    // word with no room is dropped and overflow latches.
    always_comb begin
        outData_d  = outData_q;
        outValid_d = outValid_q;
        overflow_d = overflow_q;
`ifdef BIT_PACKER_PARITY_EN
        parityErr_d = parityErr_q;
`endif
        if (wordDone && canLoad) begin
            outData_d  = collectShifted;
            outValid_d = 1'b1;
`ifdef BIT_PACKER_PARITY_EN
            parityErr_d = completedParErr;
`endif
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
        if (wordDone && !canLoad) begin
            overflow_d = 1'b1;
        end
    end

    // State registers with synchronous reset. Reset takes priority over
    // every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitCount_q  <= '0;
            collect_q   <= '0;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef BIT_PACKER_PARITY_EN
            parAcc_q    <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bitCount_q  <= bitCount_d;
            collect_q   <= collect_d;
            outData_q   <= outData_d;
            outValid_q  <= outValid_d;
            overflow_q  <= overflow_d;
`ifdef BIT_PACKER_PARITY_EN
            parAcc_q    <= parAcc_d;
            parityErr_q <= parityErr_d;
`endif
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign overflow  = overflow_q;
`ifdef BIT_PACKER_PARITY_EN
    assign parity_err = parityErr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Directed testbench for bit_packer (WIDTH=8).
// Handles both builds: with and without BIT_PACKER_PARITY_EN.
module tb_bit_packer;

`ifdef BIT_PACKER_PARITY_EN
    localparam int N = 9;
`else
    localparam int N = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       d;
    logic       d_valid;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       parity_err;

    int vectors     = 0;
    int miscompares = 0;

    bit_packer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .d_valid    (d_valid),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Build the serial frame for a data byte, with correct even parity if enabled
    function automatic logic [N-1:0] frame(input logic [7:0] w);
`ifdef BIT_PACKER_PARITY_EN
        frame = {^w, w};
`else
        frame = w;
`endif
    endfunction

    // One accepted bit per call; returns 1 unit after the capturing edge
    task automatic sendBit(input logic b);
        d       = b;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [7:0] w);
        logic [N-1:0] f;
        f = frame(w);
        for (int i = 0; i < N; i++) sendBit(f[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; d = 1'b1; d_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++;
        if (out_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 00", out_data); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        vectors++;
        if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_parity: got %b expected 0", parity_err); end
        rst = 1'b0; d_valid = 1'b0; d = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_noword: got %b expected 0", out_valid); end
    endtask

    task automatic test_basic();
        logic [N-1:0] f;
        f = frame(8'h4D);
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            sendBit(f[i]);
            if (i == N - 2) begin
                vectors++;
                if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_early: got %b expected 0", out_valid); end
            end
        end
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); end
        vectors++;
        if (out_data !== 8'h4D) begin miscompares++; $display("[TB] FAIL basic_data: got %h expected 4d", out_data); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_onecycle: got %b expected 0", out_valid); end
    endtask

    task automatic test_gaps();
        logic [N-1:0] f;
        f = frame(8'hC3);
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            sendBit(f[i]);
            if (i != N - 1) repeat (2) tick();
        end
        vectors++;
        if (out_data !== 8'hC3 || out_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL gaps_word: got %h/%b expected c3/1", out_data, out_valid);
        end
        repeat (3) tick();
        vectors++;
        if (out_data !== 8'hC3 || out_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL gaps_hold: got %h/%b expected c3/1", out_data, out_valid);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL gaps_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] f;
        out_ready = 1'b0;
        sendWord(8'h01);
        vectors++;
        if (out_data !== 8'h01 || out_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL b2b_first: got %h/%b expected 01/1", out_data, out_valid);
        end
        f = frame(8'hFF);
        for (int i = 0; i < N; i++) begin
            out_ready = (i == N - 1);
            sendBit(f[i]);
            vectors++;
            if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_bubble bit%0d: got %b expected 1", i, out_valid); end
        end
        vectors++;
        if (out_data !== 8'hFF) begin miscompares++; $display("[TB] FAIL b2b_data: got %h expected ff", out_data); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overflow: got %b expected 0", overflow); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
        d = 1'b1; d_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; d_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_noword: got %b expected 0", out_valid); end
        sendWord(8'h96);
        vectors++;
        if (out_data !== 8'h96 || out_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL flush_word: got %h/%b expected 96/1", out_data, out_valid);
        end
        tick();
        out_ready = 1'b0;
        sendWord(8'h5A);
        sendBit(1'b0); sendBit(1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if (out_data !== 8'h5A || out_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL flush_keepout: got %h/%b expected 5a/1", out_data, out_valid);
        end
        out_ready = 1'b1;
        tick();
        sendWord(8'hE7);
        vectors++;
        if (out_data !== 8'hE7 || out_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL flush_after: got %h/%b expected e7/1", out_data, out_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        sendWord(8'hA5);
        vectors++;
        if (out_data !== 8'hA5 || out_valid !== 1'b1 || overflow !== 1'b0) begin
            miscompares++; $display("[TB] FAIL bp_first: got %h/%b/%b expected a5/1/0", out_data, out_valid, overflow);
        end
        sendWord(8'h3C);
        vectors++;
        if (out_data !== 8'hA5) begin miscompares++; $display("[TB] FAIL bp_keep: got %h expected a5", out_data); end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_overflow: got %b expected 1", overflow); end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain: got %b expected 0", out_valid); end
        repeat (3) tick();
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_parity();
        logic [N-1:0] f;
        out_ready = 1'b1;
`ifdef BIT_PACKER_PARITY_EN
        f = {1'b1, 8'h03};
        for (int i = 0; i < N; i++) sendBit(f[i]);
        vectors++;
        if (out_data !== 8'h03 || parity_err !== 1'b1) begin
            miscompares++; $display("[TB] FAIL parity_bad: got %h/%b expected 03/1", out_data, parity_err);
        end
        f = {1'b0, 8'h03};
        for (int i = 0; i < N; i++) sendBit(f[i]);
        vectors++;
        if (out_data !== 8'h03 || parity_err !== 1'b0) begin
            miscompares++; $display("[TB] FAIL parity_good: got %h/%b expected 03/0", out_data, parity_err);
        end
`else
        f = frame(8'h03);
        for (int i = 0; i < N; i++) sendBit(f[i]);
        vectors++;
        if (out_data !== 8'h03 || parity_err !== 1'b0) begin
            miscompares++; $display("[TB] FAIL parity_tied: got %h/%b expected 03/0", out_data, parity_err);
        end
`endif
        tick();
    endtask

    task automatic test_reset_midword();
        out_ready = 1'b0;
        sendWord(8'h11);
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
        rst = 1'b1; d = 1'b1; d_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; d_valid = 1'b0; flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || overflow !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rstmid_clear: got %h/%b/%b expected 00/0/0", out_data, out_valid, overflow);
        end
        sendWord(8'h2B);
        vectors++;
        if (out_data !== 8'h2B || out_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL rstmid_word: got %h/%b expected 2b/1", out_data, out_valid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_flush();
        test_backpressure();
        test_parity();
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
